// File: rtl/data_memory.sv
// data_memory: word-addressed single-port RAM, synchronous write, combinational read.
// Ports: clk, reset (async, active-high, clears all words), write_enable,
//        addr (word index), writedata, readdata (word at addr).
// Optional feature macro: DATA_MEMORY_BOUNDS_CHECK_EN. When it is defined,
// addr >= DEPTH reads 0 and ignores writes. When it is not defined, addr wraps modulo DEPTH.
module data_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] writedata,
    output logic [DATA_WIDTH-1:0] readdata
);
    localparam int IDX = $clog2(DEPTH);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IDX-1:0]        idx;
    logic                  in_range;
    assign idx = addr[IDX-1:0];
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
    assign in_range = addr < ADDR_WIDTH'(DEPTH);
`else
    // Upper address bits are deliberately dropped so that the address wraps.
    logic addr_unused;
    assign addr_unused = ^addr;
    assign in_range = 1'b1;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (write_enable && in_range) begin
            mem[idx] <= writedata;
        end
    end
    assign readdata = in_range ? mem[idx] : '0;
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed + random self-checking bench for data_memory.
module tb_data_memory;
    localparam int DEPTH = 64;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write_enable = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [31:0] model [DEPTH];
    int          tests = 0;
    int          fails = 0;
    data_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .write_enable(write_enable),
        .addr(addr),
        .writedata(writedata),
        .readdata(readdata)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] ref_rd(logic [31:0] a);
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
        return (a < DEPTH) ? model[a] : 32'h0;
`else
        return model[a % DEPTH];
`endif
    endfunction
    function automatic void ref_wr(logic [31:0] a, logic [31:0] d);
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
        if (a < DEPTH) model[a] = d;
`else
        model[a % DEPTH] = d;
`endif
    endfunction
    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    endtask
    task automatic check(string tag, logic [31:0] exp);
        #1;
        tests++;
        assert (readdata === exp) else begin
            fails++;
            $error("FAIL %s addr=%0d got=%h expected=%h", tag, addr, readdata, exp);
        end
    endtask
    task automatic check_at(string tag, logic [31:0] a);
        addr = a;
        check(tag, ref_rd(a));
    endtask
    task automatic do_write(logic [31:0] a, logic [31:0] d);
        @(negedge clk);
        addr = a;
        writedata = d;
        write_enable = 1'b1;
        @(posedge clk);
        ref_wr(a, d);
        #1;
        write_enable = 1'b0;
        check("write", ref_rd(a));
    endtask
    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic        we;
        clear_model();
        // reset asserted: every word reads zero
        #2;
        for (int i = 0; i < DEPTH; i++) begin
            addr = i;
            check("reset_sweep", 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            addr = i;
            check("post_reset_sweep", 32'h0);
        end
        // word 0, then an idle edge with different writedata
        do_write(0, 32'hFFFF_FFFF);
        @(negedge clk);
        writedata = 32'h1234_5678;
        @(posedge clk);
        check("we0_hold", 32'hFFFF_FFFF);
        // independent words
        do_write(1, 32'h0000_FFFF);
        do_write(2, 32'h0000_0000);
        addr = 0; check("word0", 32'hFFFF_FFFF);
        addr = 1; check("word1", 32'h0000_FFFF);
        addr = 2; check("word2", 32'h0000_0000);
        // read during write: old before the edge, new after
        @(negedge clk);
        addr = 1;
        writedata = 32'hA5A5_A5A5;
        write_enable = 1'b1;
        check("rdw_before", 32'h0000_FFFF);
        @(posedge clk);
        ref_wr(1, 32'hA5A5_A5A5);
        check("rdw_after", 32'hA5A5_A5A5);
        write_enable = 1'b0;
        // asynchronous reset mid-run
        @(negedge clk);
        addr = 0;
        #2;
        reset = 1'b1;
        clear_model();
        check("async_reset", 32'h0);
        writedata = 32'h5555_AAAA;
        write_enable = 1'b1;
        @(posedge clk);
        check("write_in_reset", 32'h0);
        @(negedge clk);
        write_enable = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) check_at("after_async_reset", i);
        // beyond DEPTH
        do_write(0, 32'h0BAD_F00D);
        do_write(64, 32'hDEAD_BEEF);
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
        addr = 0;  check("oob_word0", 32'h0BAD_F00D);
        addr = 64; check("oob_read", 32'h0);
`else
        addr = 0;  check("alias_word0", 32'hDEAD_BEEF);
        addr = 64; check("alias_read", 32'hDEAD_BEEF);
`endif
        // random traffic including out-of-range and wide addresses
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            a = ($urandom_range(0, 9) == 0) ? $urandom() : $urandom_range(0, 2 * DEPTH - 1);
            d = $urandom();
            we = $urandom_range(0, 1);
            addr = a;
            writedata = d;
            write_enable = we;
            check("rand_pre", ref_rd(a));
            @(posedge clk);
            if (we) ref_wr(a, d);
            check("rand_post", ref_rd(a));
            // inputs changing mid-cycle must not affect contents
            writedata = ~d;
            addr = a + 1;
            check("rand_mid", ref_rd(a + 1));
        end
        @(negedge clk);
        write_enable = 1'b0;
        for (int i = 0; i < 2 * DEPTH; i++) check_at("final_sweep", i);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
